// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 single-slave master with start/busy/done host handshake
// Optional: define SPI_MASTER_LSB_FIRST_EN for LSB-first bit order (timing unchanged).
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         len,
  input  logic [MAX_LEN-1:0] tx_data,
  output logic [MAX_LEN-1:0] rx_data,
  output logic               busy,
  output logic               done,
  output logic               sck,
  output logic               ss,
  output logic               mosi,
  input  logic               miso
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $fatal(1, "spi_master: CLK_DIV must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

  state_t             state;
  state_t             state_next;
  logic [DW-1:0]      div_cnt;
  logic               tick;
  logic [CW-1:0]      len_eff;
  logic [CW-1:0]      len_q;
  logic [CW-1:0]      bit_cnt;
  logic [MAX_LEN-1:0] tx_shift;
  logic [MAX_LEN-1:0] rx_shift;
  logic [MAX_LEN-1:0] tx_load;
  logic [MAX_LEN-1:0] tx_adv;
  logic [MAX_LEN-1:0] rx_in;
  logic [MAX_LEN-1:0] rx_final;
  logic               first_bit;
  logic               next_bit;

  assign tick = (div_cnt == DW'(CLK_DIV - 1));

  always_comb begin
    len_eff = CW'(MAX_LEN);
    if (len != 5'd0 && 32'(len) <= MAX_LEN) len_eff = CW'(len);
  end

  // The shift registers keep the bit on the wire at one fixed end.
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign tx_load   = tx_data;
  assign first_bit = tx_data[0];
  assign tx_adv    = tx_shift >> 1;
  assign next_bit  = tx_shift[1];
  assign rx_in     = {miso, rx_shift[MAX_LEN-1:1]};
  assign rx_final  = rx_shift >> (CW'(MAX_LEN) - len_q);
`else
  assign tx_load   = tx_data << (CW'(MAX_LEN) - len_eff);
  assign first_bit = tx_load[MAX_LEN-1];
  assign tx_adv    = tx_shift << 1;
  assign next_bit  = tx_shift[MAX_LEN-2];
  assign rx_in     = {rx_shift[MAX_LEN-2:0], miso};
  assign rx_final  = rx_shift;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (start) state_next = SETUP;
      SETUP, LOW: if (tick) state_next = HIGH;
      HIGH:       if (tick) state_next = (bit_cnt == len_q) ? HOLD : LOW;
      HOLD:       if (tick) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      len_q    <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sck      <= 1'b0;
      ss       <= 1'b1;
      mosi     <= 1'b1;
    end else begin
      done <= 1'b0;
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + DW'(1);

      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len_eff;
            bit_cnt  <= '0;
            tx_shift <= tx_load;
            rx_shift <= '0;
            mosi     <= first_bit;
            ss       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SETUP, LOW: begin
          // miso is taken on the same edge that raises sck
          if (tick) begin
            sck      <= 1'b1;
            rx_shift <= rx_in;
            bit_cnt  <= bit_cnt + CW'(1);
          end
        end
        HIGH: begin
          if (tick) begin
            sck <= 1'b0;
            if (bit_cnt != len_q) begin
              tx_shift <= tx_adv;
              mosi     <= next_bit;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            ss      <= 1'b1;
            mosi    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_final;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
